// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, hazard-controller state encoding
// and the per-stage control bundle driven by the hazard controller.
package cpu_pkg;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    DRAIN    = ST_DRAIN,
    HALTED   = ST_HALTED
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } stage_ctrl_t;

  // Stall and drain share one pattern: hold the front end, push a bubble into EX.
  localparam stage_ctrl_t CTRL_RUN    = 7'b1101011;
  localparam stage_ctrl_t CTRL_STALL  = 7'b0001111;
  localparam stage_ctrl_t CTRL_BRANCH = 7'b1111011;
  localparam stage_ctrl_t CTRL_HLT    = 7'b0111011;
  localparam stage_ctrl_t CTRL_RESET  = 7'b0010100;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): hazard-relevant stage fields in, per-stage strobes out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0]       id_opcode;
  logic [3:0]       id_srcA;
  logic [3:0]       id_srcB;
  logic             id_usesA;
  logic             id_usesB;
  logic             id_branch;
  logic             id_branchTake;
  logic             ex_memRead;
  logic [3:0]       ex_dstReg;
  logic             ex_setsFlags;
  logic             mem_access;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_opcode, id_srcA, id_srcB, id_usesA, id_usesB, id_branch, id_branchTake,
    output ex_memRead, ex_dstReg, ex_setsFlags, mem_access, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
    input  halted, stall_count
  );

  modport slave (
    input  id_opcode, id_srcA, id_srcB, id_usesA, id_usesB, id_branch, id_branchTake,
    input  ex_memRead, ex_dstReg, ex_setsFlags, mem_access, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
    output halted, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational dependency check between the ID instruction and the EX instruction.
module hazard_detect (
  input  logic       ex_memRead_i,
  input  logic [3:0] ex_dstReg_i,
  input  logic       ex_setsFlags_i,
  input  logic [3:0] id_srcA_i,
  input  logic [3:0] id_srcB_i,
  input  logic       id_usesA_i,
  input  logic       id_usesB_i,
  input  logic       id_branch_i,
  output logic       load_use_o,
  output logic       flag_dep_o
);
  logic match_a;
  logic match_b;

  assign match_a = id_usesA_i && (id_srcA_i == ex_dstReg_i);
  assign match_b = id_usesB_i && (id_srcB_i == ex_dstReg_i);

  // R0 is hardwired, so a load targeting it never produces a dependency.
  assign load_use_o = ex_memRead_i && (ex_dstReg_i != 4'd0) && (match_a || match_b);
  assign flag_dep_o = id_branch_i && ex_setsFlags_i;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, freezes, flushes and HLT drain for
// the 5-stage pipeline, plus a saturating stall-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_e          state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   stall_q;
  stage_ctrl_t        ctrl;
  logic               load_use, flag_dep, mem_hold;

  hazard_detect u_detect (
    .ex_memRead_i   (bus.ex_memRead),
    .ex_dstReg_i    (bus.ex_dstReg),
    .ex_setsFlags_i (bus.ex_setsFlags),
    .id_srcA_i      (bus.id_srcA),
    .id_srcB_i      (bus.id_srcB),
    .id_usesA_i     (bus.id_usesA),
    .id_usesB_i     (bus.id_usesB),
    .id_branch_i    (bus.id_branch),
    .load_use_o     (load_use),
    .flag_dep_o     (flag_dep)
  );

  assign mem_hold = bus.mem_access && !bus.mem_ready;

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    drain_d = drain_q;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          // MEM_WAIT falls through to the RUN rules in its mem_ready cycle.
          if (state_q == MEM_WAIT && !bus.mem_ready) begin
            ctrl = '0;
          end else if (mem_hold) begin
            state_d = MEM_WAIT;
          end else begin
            state_d = RUN;
            if (load_use || flag_dep) begin
              ctrl = CTRL_STALL;
            end else if (bus.id_branchTake) begin
              ctrl = CTRL_BRANCH;
            end else if (bus.id_opcode == OP_HLT) begin
              ctrl    = CTRL_HLT;
              state_d = DRAIN;
              drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
            end else begin
              ctrl = CTRL_RUN;
            end
          end
        end
        DRAIN: begin
          if (!mem_hold) begin
            ctrl = CTRL_STALL;
            if (drain_q == '0) state_d = HALTED;
            else               drain_d = drain_q - DRAIN_W'(1);
          end
        end
        HALTED:  ctrl = '0;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (!ctrl.pc_en && state_q != HALTED && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.halted      = (state_q == HALTED) && !rst;
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus a randomized run checked against a cycle-level
// behavioural model of the sequencing rules.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int DRAIN = 3;
  localparam int SAT   = (1 << CNT_W) - 1;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] E_RUN    = 7'b1101011;
  localparam logic [6:0] E_STALL  = 7'b0001111;
  localparam logic [6:0] E_BRANCH = 7'b1111011;
  localparam logic [6:0] E_HLT    = 7'b0111011;
  localparam logic [6:0] E_RST    = 7'b0010100;
  localparam logic [6:0] E_ZERO   = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
  hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int m_drain_left;
  bit m_wait;
  bit m_halted;
  int m_stalls;

  function automatic logic [6:0] obs();
    return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
            hif.idex_flush, hif.exmem_en, hif.memwb_en};
  endfunction

  task automatic idle();
    hif.id_opcode = 4'h0; hif.id_srcA = 4'h0; hif.id_srcB = 4'h0;
    hif.id_usesA = 1'b0; hif.id_usesB = 1'b0; hif.id_branch = 1'b0;
    hif.id_branchTake = 1'b0; hif.ex_memRead = 1'b0; hif.ex_dstReg = 4'h0;
    hif.ex_setsFlags = 1'b0; hif.mem_access = 1'b0; hif.mem_ready = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    hif.mem_access = 1'b1;
    hif.id_opcode  = 4'hF;
    settle();
    n_checks++;
    if (obs() !== E_RST || hif.halted !== 1'b0) $display("FAIL reset_outputs got=%b/%b exp=%b/0", obs(), hif.halted, E_RST);
    else n_pass++;
    cycle();
    rst = 1'b0;
    idle();
    settle();
    n_checks++;
    if (obs() !== E_RUN || hif.stall_count !== 0) $display("FAIL reset_state got=%b cnt=%0d exp=%b cnt=0", obs(), hif.stall_count, E_RUN);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    hif.ex_memRead = 1'b1; hif.ex_dstReg = 4'd3; hif.id_usesA = 1'b1; hif.id_srcA = 4'd3;
    settle();
    n_checks++;
    if (obs() !== E_STALL) $display("FAIL load_use_a got=%b exp=%b", obs(), E_STALL);
    else n_pass++;
    cycle();
    idle();
    settle();
    n_checks++;
    if (obs() !== E_RUN || hif.stall_count !== 1) $display("FAIL load_use_after got=%b cnt=%0d exp=%b cnt=1", obs(), hif.stall_count, E_RUN);
    else n_pass++;
    hif.ex_memRead = 1'b1; hif.ex_dstReg = 4'd5; hif.id_usesB = 1'b1; hif.id_srcB = 4'd5;
    hif.id_srcA = 4'd5;
    settle();
    n_checks++;
    if (obs() !== E_STALL) $display("FAIL load_use_b got=%b exp=%b", obs(), E_STALL);
    else n_pass++;
    hif.id_usesB = 1'b0;
    settle();
    n_checks++;
    if (obs() !== E_RUN) $display("FAIL load_use_unused_src got=%b exp=%b", obs(), E_RUN);
    else n_pass++;
    cycle();
  endtask

  task automatic test_reg0();
    do_reset();
    hif.ex_memRead = 1'b1; hif.ex_dstReg = 4'd0; hif.id_usesA = 1'b1; hif.id_srcA = 4'd0;
    hif.id_usesB = 1'b1; hif.id_srcB = 4'd0;
    settle();
    n_checks++;
    if (obs() !== E_RUN) $display("FAIL reg0_no_stall got=%b exp=%b", obs(), E_RUN);
    else n_pass++;
    cycle();
    idle();
    settle();
    n_checks++;
    if (hif.stall_count !== 0) $display("FAIL reg0_count got=%0d exp=0", hif.stall_count);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      hif.mem_access = 1'b1; hif.mem_ready = 1'b0;
      settle();
      n_checks++;
      if (obs() !== E_ZERO) $display("FAIL mem_wait_hold%0d got=%b exp=%b", i, obs(), E_ZERO);
      else n_pass++;
      cycle();
    end
    // completing cycle applies normal rules: a taken branch flushes
    hif.mem_ready = 1'b1; hif.id_branch = 1'b1; hif.id_branchTake = 1'b1;
    settle();
    n_checks++;
    if (obs() !== E_BRANCH) $display("FAIL mem_wait_resume got=%b exp=%b", obs(), E_BRANCH);
    else n_pass++;
    cycle();
    idle();
    settle();
    n_checks++;
    if (obs() !== E_RUN || hif.stall_count !== 4) $display("FAIL mem_wait_count got=%b cnt=%0d exp=%b cnt=4", obs(), hif.stall_count, E_RUN);
    else n_pass++;
  endtask

  task automatic test_flag_branch();
    do_reset();
    hif.ex_setsFlags = 1'b1; hif.id_branch = 1'b1; hif.id_branchTake = 1'b1; hif.id_opcode = 4'hC;
    settle();
    n_checks++;
    if (obs() !== E_STALL) $display("FAIL flag_dep_stall got=%b exp=%b", obs(), E_STALL);
    else n_pass++;
    cycle();
    hif.ex_setsFlags = 1'b0;
    settle();
    n_checks++;
    if (obs() !== E_BRANCH) $display("FAIL flag_dep_taken got=%b exp=%b", obs(), E_BRANCH);
    else n_pass++;
    cycle();
    idle();
    settle();
    n_checks++;
    if (hif.stall_count !== 1) $display("FAIL flag_dep_count got=%0d exp=1", hif.stall_count);
    else n_pass++;
  endtask

  task automatic test_halt_drain();
    logic [6:0] exp_seq [7];
    logic       hold_seq [7];
    exp_seq  = '{E_DRAIN_PLACE(), E_ZERO, E_ZERO, E_STALL, E_STALL, E_ZERO, E_ZERO};
    hold_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    hif.id_opcode = 4'hF;
    settle();
    n_checks++;
    if (obs() !== E_HLT) $display("FAIL hlt_decode got=%b exp=%b", obs(), E_HLT);
    else n_pass++;
    cycle();
    for (int i = 0; i < 7; i++) begin
      idle();
      hif.id_opcode  = 4'h1;
      hif.mem_access = hold_seq[i];
      settle();
      n_checks++;
      if (obs() !== exp_seq[i] || hif.halted !== (i >= 5)) $display("FAIL drain_step%0d got=%b halted=%b exp=%b halted=%b", i, obs(), hif.halted, exp_seq[i], (i >= 5));
      else n_pass++;
      cycle();
    end
    n_checks++;
    if (hif.stall_count !== 6) $display("FAIL drain_count got=%0d exp=6", hif.stall_count);
    else n_pass++;
  endtask

  function automatic logic [6:0] E_DRAIN_PLACE();
    return E_STALL;
  endfunction

  task automatic test_reset_midway();
    // entered from HALTED
    rst = 1'b1;
    settle();
    n_checks++;
    if (obs() !== E_RST || hif.halted !== 1'b0) $display("FAIL rst_halted_during got=%b/%b exp=%b/0", obs(), hif.halted, E_RST);
    else n_pass++;
    cycle();
    rst = 1'b0;
    idle();
    settle();
    n_checks++;
    if (obs() !== E_RUN || hif.halted !== 1'b0 || hif.stall_count !== 0) $display("FAIL rst_halted_after got=%b/%b cnt=%0d exp=%b/0 cnt=0", obs(), hif.halted, hif.stall_count, E_RUN);
    else n_pass++;
    hif.mem_access = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle();
    settle();
    n_checks++;
    if (obs() !== E_RUN || hif.stall_count !== 0) $display("FAIL rst_memwait_after got=%b cnt=%0d exp=%b cnt=0", obs(), hif.stall_count, E_RUN);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    hif.mem_access = 1'b1;
    for (int i = 0; i < SAT + 5; i++) cycle();
    idle();
    settle();
    n_checks++;
    if (hif.stall_count !== SAT[CNT_W-1:0]) $display("FAIL stall_saturate got=%0d exp=%0d", hif.stall_count, SAT);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_drain_left = 0; m_wait = 1'b0; m_halted = 1'b0; m_stalls = 0;
  endtask

  task automatic test_random();
    logic [6:0] exp;
    logic       exp_halt;
    bit         hold, lu, fd, was_halted;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      rst               = ($urandom_range(0, 59) == 0);
      hif.id_opcode     = ($urandom_range(0, 24) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      hif.id_srcA       = 4'($urandom_range(0, 3));
      hif.id_srcB       = 4'($urandom_range(0, 3));
      hif.id_usesA      = 1'($urandom_range(0, 1));
      hif.id_usesB      = 1'($urandom_range(0, 1));
      hif.id_branch     = ($urandom_range(0, 3) == 0);
      hif.id_branchTake = hif.id_branch & 1'($urandom_range(0, 1));
      hif.ex_memRead    = ($urandom_range(0, 2) == 0);
      hif.ex_dstReg     = 4'($urandom_range(0, 3));
      hif.ex_setsFlags  = 1'($urandom_range(0, 1));
      hif.mem_access    = ($urandom_range(0, 3) == 0);
      hif.mem_ready     = 1'($urandom_range(0, 1));
      settle();

      hold = hif.mem_access && !hif.mem_ready;
      lu   = hif.ex_memRead && hif.ex_dstReg != 0 &&
             ((hif.id_usesA && hif.id_srcA == hif.ex_dstReg) ||
              (hif.id_usesB && hif.id_srcB == hif.ex_dstReg));
      fd   = hif.id_branch && hif.ex_setsFlags;
      was_halted = m_halted;
      exp_halt   = 1'b0;
      if (rst) exp = E_RST;
      else if (m_halted) begin
        exp = E_ZERO; exp_halt = 1'b1;
      end else if (m_drain_left > 0) begin
        if (hold) exp = E_ZERO;
        else begin
          exp = E_STALL;
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1'b1;
        end
      end else if (m_wait && !hif.mem_ready) exp = E_ZERO;
      else begin
        m_wait = 1'b0;
        if (hold) begin exp = E_ZERO; m_wait = 1'b1; end
        else if (lu || fd) exp = E_STALL;
        else if (hif.id_branchTake) exp = E_BRANCH;
        else if (hif.id_opcode == 4'hF) begin exp = E_HLT; m_drain_left = DRAIN; end
        else exp = E_RUN;
      end

      n_checks++;
      if (obs() !== exp || hif.halted !== exp_halt || hif.stall_count !== m_stalls[CNT_W-1:0])
        $display("FAIL random cyc=%0d got=%b halted=%b cnt=%0d exp=%b halted=%b cnt=%0d",
                 c, obs(), hif.halted, hif.stall_count, exp, exp_halt, m_stalls);
      else n_pass++;

      if (rst) model_reset();
      else if (!exp[6] && !was_halted && m_stalls < SAT) m_stalls++;
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_reg0();
    test_mem_wait();
    test_flag_branch();
    test_halt_drain();
    test_reset_midway();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Detects load-use and flag-dependency hazards for the instruction in ID.
- Freezes the whole pipeline while a multi-cycle data-memory access in MEM is outstanding.
- Flushes IF/ID on a taken branch; drains and halts the pipeline on HLT.
- Drives per-stage enable/flush strobes plus a stall performance counter.

Parameters:
DRAIN_CYCLES, 3, cycles after HLT decode before HALTED (EX/MEM/WB retire)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_opcode  in  4  opcode of instruction in ID
id_srcA  in  4  first source register read in ID
id_srcB  in  4  second source register read in ID
id_usesA  in  1  ID instruction actually reads id_srcA
id_usesB  in  1  ID instruction actually reads id_srcB
id_branch  in  1  ID instruction is B or BR
id_branchTake  in  1  branch resolved taken in ID
ex_memRead  in  1  EX instruction is a load
ex_dstReg  in  4  EX destination register
ex_setsFlags  in  1  EX instruction updates Z/V/N
mem_access  in  1  MEM stage holds a load/store
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX loads bubble (all controls 0)
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
halted  out  1  pipeline halted
stall_count  out  CNT_W  stall cycles since reset

Behaviour:
- State register, states RUN, MEM_WAIT, DRAIN, HALTED. Reset (rst high at edge): state=RUN, drain counter=0, stall_count=0.
- Outputs are combinational from state and inputs. No added latency: a stall applies in the same cycle the hazard is visible.
- While rst is high: all *_en=0, ifid_flush=1, idex_flush=1, halted=0.
- load_use = ex_memRead & ex_dstReg!=0 & ((id_usesA & id_srcA==ex_dstReg) | (id_usesB & id_srcB==ex_dstReg)).
- flag_dep = id_branch & ex_setsFlags.
- mem_hold = mem_access & ~mem_ready.
- RUN, evaluated in this priority order:
  - mem_hold: all enables 0, no flushes, next=MEM_WAIT.
  - Else load_use | flag_dep: pc_en=0, ifid_en=0, idex_flush=1, exmem_en/memwb_en=1. id_branchTake is ignored this cycle.
  - Else id_branchTake: ifid_flush=1, all enables 1.
  - Else id_opcode==4'hF (HLT): pc_en=0, ifid_flush=1, idex_en=1, next=DRAIN, drain counter=DRAIN_CYCLES-1.
  - Else all enables 1, no flushes.
- MEM_WAIT: all enables 0 until mem_ready=1. In the mem_ready cycle, return to RUN, and the RUN rules apply to that cycle with mem_hold=0.
- DRAIN: pc_en=0, ifid_en=0, idex_flush=1, exmem_en/memwb_en=1. mem_hold freezes the drain: enables 0, counter holds. Counter decrements otherwise; on 0, next=HALTED.
- HALTED: all enables 0, halted=1. Only rst exits.
- stall_count increments each cycle where pc_en=0 and state!=HALTED and rst=0. It saturates at all-ones (no wrap).
- Register 0 is never a hazard: it is hardwired, so the ex_dstReg!=0 check applies.
- rst asserted mid-MEM_WAIT or mid-DRAIN: return to RUN next cycle, counters cleared.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_HLT=4'hF, OP_B, OP_BR, OP_LW, OP_SW, OP_LLB, OP_LHB) and state encoding localparams for hazard_ctrl.
- One sub-module: hazard_detect, pure combinational, producing load_use and flag_dep. FSM, drain counter and stall counter stay in hazard_ctrl.

Test Plan:
- LW R3 in EX (ex_memRead=1, ex_dstReg=3), ID ADD reads R3 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_count=1.
- Same scenario with ex_dstReg=0 -> no stall, stall_count stays 0.
- mem_access=1, mem_ready=0 for 4 cycles then 1 -> all enables 0 for 4 cycles, resume on 5th; stall_count=4.
- ADD (ex_setsFlags=1) in EX, B taken in ID -> 1 stall cycle with no ifid_flush; following cycle ifid_flush=1, pc_en=1.
- HLT in ID -> DRAIN for 3 cycles, then halted=1 with all enables 0. A mem_hold during DRAIN extends it by the hold length.
- rst pulse while in HALTED or MEM_WAIT -> state RUN, halted=0, stall_count=0 on next cycle.
